serializador_morse: RTL

//  Downstream stage of the 16:1 5-bit code mux in the Morse transmitter.

---
 rtl/morse_pkg.sv | 18 +
 rtl/contador_duracion.sv | 26 ++
 rtl/serializador_morse.sv | 110 +++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared FSM encoding and Morse timing constants
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MARCA     = 2'd1,
    ESPACIO   = 2'd2,
    PAUSA_CAR = 2'd3
  } estado_t;

  localparam int U_PUNTO    = 1;
  localparam int U_RAYA     = 3;
  localparam int U_ESP_ELEM = 1;
  localparam int U_ESP_CAR  = 3;

  localparam int N_SIMB_DEF = 5;

endpackage

// File: rtl/contador_duracion.sv
// rtl/contador_duracion.sv - loadable down-counter that holds at zero
module contador_duracion #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         carga,
  input  logic [W-1:0] valor,
  output logic         cero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (carga) begin
      cnt_q <= valor;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cero = (cnt_q == '0);

endmodule

// File: rtl/serializador_morse.sv
// rtl/serializador_morse.sv - keys a latched Morse code word out as timed marks and spaces
module serializador_morse
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 5_000_000,
  parameter int N_SIMB      = N_SIMB_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SIMB-1:0] codigo,
  input  logic              inicio,
  output logic              salida_morse,
  output logic              ocupado,
  output logic              fin
);

  localparam int CW = $clog2(3 * UNIT_CYCLES);
  localparam int IW = (N_SIMB > 1) ? $clog2(N_SIMB) : 1;

  localparam logic [CW-1:0] D_PUNTO    = CW'(U_PUNTO * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] D_RAYA     = CW'(U_RAYA * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] D_ESP_ELEM = CW'(U_ESP_ELEM * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] D_ESP_CAR  = CW'(U_ESP_CAR * UNIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_SIMB - 1);

  estado_t           estado_q, estado_d;
  logic [N_SIMB-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              salida_q, ocupado_q, fin_q;
  logic              carga, cero;
  logic [CW-1:0]     valor;

  contador_duracion #(.W(CW)) u_contador (
    .clk   (clk),
    .rst_n (rst_n),
    .carga (carga),
    .valor (valor),
    .cero  (cero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      salida_q  <= 1'b0;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      salida_q  <= (estado_d == MARCA);
      ocupado_q <= (estado_d != IDLE);
      fin_q     <= (estado_q == PAUSA_CAR) && (estado_d == IDLE);
    end
  end

  // The counter is reloaded on every state change; each phase ends when it reads zero.
  always_comb begin
    estado_d = estado_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    carga    = 1'b0;
    valor    = D_PUNTO;
    case (estado_q)
      IDLE: begin
        if (inicio) begin
          estado_d = MARCA;
          shreg_d  = codigo;
          idx_d    = '0;
          carga    = 1'b1;
          valor    = codigo[N_SIMB-1] ? D_RAYA : D_PUNTO;
        end
      end
      MARCA: begin
        if (cero) begin
          carga = 1'b1;
          if (idx_q == IDX_LAST) begin
            estado_d = PAUSA_CAR;
            valor    = D_ESP_CAR;
          end else begin
            estado_d = ESPACIO;
            valor    = D_ESP_ELEM;
          end
        end
      end
      ESPACIO: begin
        if (cero) begin
          estado_d = MARCA;
          shreg_d  = {shreg_q[N_SIMB-2:0], 1'b0};
          idx_d    = idx_q + IW'(1);
          carga    = 1'b1;
          valor    = shreg_q[N_SIMB-2] ? D_RAYA : D_PUNTO;
        end
      end
      PAUSA_CAR: begin
        if (cero) begin
          estado_d = IDLE;
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  assign salida_morse = salida_q;
  assign ocupado      = ocupado_q;
  assign fin          = fin_q;

endmodule
